sumador_serie_param: RTL and testbench



---
 rtl/sumador_serie_param.sv | 102 ++++++++++
 tb/tb_sumador_serie_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serie_param.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first.
// Valid/ready on both sides; result registers hold until the next acceptance.
module sumador_serie_param #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    input  logic             i_resta,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_suma,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_suma;
    logic             r_carry;
    logic             r_ovf;

    logic [CHUNK:0]   w_sum;
    logic             w_c_msb;
    logic             w_last;

    // Operands shift right each slice, so the active slice is always bits [CHUNK-1:0].
    always_comb begin
        w_sum = {1'b0, r_a[CHUNK-1:0]}
              + {1'b0, r_b[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, r_cin};
        w_c_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1];
        w_last  = (r_cnt == CW'(N - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_cnt   <= '0;
            r_suma  <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_resta ? ~i_b : i_b;
                        r_cin   <= i_resta | i_carry;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_a    <= r_a >> CHUNK;
                    r_b    <= r_b >> CHUNK;
                    r_cin  <= w_sum[CHUNK];
                    r_cnt  <= r_cnt + 1'b1;
                    // New slice enters at the top; after N shifts slice 0 sits at the bottom.
                    r_suma <= (r_suma >> CHUNK)
                            | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
                    if (w_last) begin
                        r_carry <= w_sum[CHUNK];
                        r_ovf   <= w_c_msb ^ w_sum[CHUNK];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready    = (r_state == S_IDLE);
    assign o_valid    = (r_state == S_DONE);
    assign o_suma     = r_suma;
    assign o_carry    = r_carry;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_sumador_serie_param.sv
// Bench for sumador_serie_param: an 8/4 build and an 8/8 build side by side,
// expected results queued at issue and compared when o_valid appears.
module tb_sumador_serie_param;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       valid_i [2];
    logic       ready_i [2];
    logic [7:0] a_i     [2];
    logic [7:0] b_i     [2];
    logic       cin_i   [2];
    logic       sub_i   [2];
    logic       rdy_o   [2];
    logic       vld_o   [2];
    logic [7:0] sum_o   [2];
    logic       cout_o  [2];
    logic       ovf_o   [2];

    exp_t sb[$];
    int   ncmp;
    int   nerr;
    int   lat;

    sumador_serie_param #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(valid_i[0]), .o_ready(rdy_o[0]),
        .i_a(a_i[0]), .i_b(b_i[0]),
        .i_carry(cin_i[0]), .i_resta(sub_i[0]),
        .o_valid(vld_o[0]), .i_ready(ready_i[0]),
        .o_suma(sum_o[0]), .o_carry(cout_o[0]),
        .o_overflow(ovf_o[0])
    );

    sumador_serie_param #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(valid_i[1]), .o_ready(rdy_o[1]),
        .i_a(a_i[1]), .i_b(b_i[1]),
        .i_carry(cin_i[1]), .i_resta(sub_i[1]),
        .o_valid(vld_o[1]), .i_ready(ready_i[1]),
        .o_suma(sum_o[1]), .o_carry(cout_o[1]),
        .o_overflow(ovf_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int d);
        chk("rst_ready", 32'(rdy_o[d]), 32'd1);
        chk("rst_valid", 32'(vld_o[d]), 32'd0);
        chk("rst_suma", 32'(sum_o[d]), 32'd0);
        chk("rst_carry", 32'(cout_o[d]), 32'd0);
        chk("rst_ovf", 32'(ovf_o[d]), 32'd0);
    endtask

    task automatic start_op(input int d, input logic [7:0] a,
                            input logic [7:0] b, input logic cin,
                            input logic sub, input bit poke);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] t;
        int         n;
        bb  = sub ? ~b : b;
        t   = 9'(a) + 9'(bb) + 9'(sub | cin);
        e.s = t[7:0];
        e.c = t[8];
        e.v = (a[7] == bb[7]) && (t[7] != a[7]);
        n = 0;
        while (!rdy_o[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_op", 32'(rdy_o[d]), 32'd1);
        a_i[d]     = a;
        b_i[d]     = b;
        cin_i[d]   = cin;
        sub_i[d]   = sub;
        valid_i[d] = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        lat = 1;
        valid_i[d] = 1'b0;
        a_i[d]     = 8'($urandom);
        b_i[d]     = 8'($urandom);
        sub_i[d]   = ~sub;
        cin_i[d]   = ~cin;
        chk("ready_in_calc", 32'(rdy_o[d]), 32'd0);
        if (poke) begin
            valid_i[d] = 1'b1;
            @(posedge clk); #1;
            lat++;
            valid_i[d] = 1'b0;
            a_i[d]     = 8'($urandom);
        end
    endtask

    task automatic finish_op(input int d, input int exp_lat,
                             input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!vld_o[d] && n < 50) begin
            @(posedge clk); #1;
            lat++;
            n++;
        end
        chk("valid_seen", 32'(vld_o[d]), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("suma", 32'(sum_o[d]), 32'(e.s));
            chk("carry", 32'(cout_o[d]), 32'(e.c));
            chk("overflow", 32'(ovf_o[d]), 32'(e.v));
            chk("ready_in_done", 32'(rdy_o[d]), 32'd0);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_valid", 32'(vld_o[d]), 32'd1);
                chk("hold_ready", 32'(rdy_o[d]), 32'd0);
                chk("hold_suma", 32'(sum_o[d]), 32'(e.s));
                chk("hold_carry", 32'(cout_o[d]), 32'(e.c));
                chk("hold_ovf", 32'(ovf_o[d]), 32'(e.v));
            end
        end
        ready_i[d] = 1'b1;
        @(posedge clk); #1;
        ready_i[d] = 1'b0;
        chk("valid_drop", 32'(vld_o[d]), 32'd0);
        chk("ready_back", 32'(rdy_o[d]), 32'd1);
    endtask

    initial begin
        ncmp  = 0;
        nerr  = 0;
        lat   = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid_i[d] = 1'b0;
            ready_i[d] = 1'b0;
            a_i[d]     = 8'h00;
            b_i[d]     = 8'h00;
            cin_i[d]   = 1'b0;
            sub_i[d]   = 1'b0;
        end
        #23;
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        start_op(0, 8'h3C, 8'h4A, 1'b0, 1'b0, 1'b0);
        finish_op(0, 3, 0);
        start_op(0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        finish_op(0, 3, 0);
        start_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
        finish_op(0, 3, 0);
        for (int i = 0; i < 6; i++) begin
            start_op(0, 8'($urandom), 8'($urandom), 1'($urandom),
                     1'($urandom), 1'b0);
            finish_op(0, 3, 0);
        end
        start_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        finish_op(0, 3, 5);

        // Abort during slice 0: outputs clear at once, no result follows.
        start_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        void'(sb.pop_back());
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(vld_o[0]), 32'd0);
        end
        chk("abort_ready", 32'(rdy_o[0]), 32'd1);

        start_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        finish_op(1, 2, 0);
        start_op(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        finish_op(1, 2, 2);
        start_op(1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1);
        finish_op(1, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
